bus_ctrl_sequencer: RTL

- Hardwired control-step sequencer for the single-bus datapath.
- Steps fetch and execute for the supported instruction subset.
- Every cycle it emits one-hot bus-driver enables (bit order = bus select index), register load enables, ALU op and memory read.
- Sits between IR/memory and the bus mux, registers, Y/Z/ALU, MAR/MDR and PC.

---
 rtl/bus_ctrl_pkg.sv | 63 ++++++
 rtl/bus_ctrl_sequencer_decode.sv | 50 +++++
 rtl/bus_ctrl_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bus_ctrl_pkg
// Shared definitions for the single-bus control sequencer:
//   - opcode values (ir[31:27])
//   - bus driver indices for the non-GPR drivers (GPRs occupy 0..15)
//   - sequencer state enum and decoded-instruction struct
// Optional build macro: SINGLE_STEP_EN adds the PAUSE state.
// -----------------------------------------------------------------------------
package bus_ctrl_pkg;

   localparam logic [4:0] OP_LD   = 5'd0;
   localparam logic [4:0] OP_LDI  = 5'd1;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_ROR  = 5'd7;
   localparam logic [4:0] OP_ROL  = 5'd8;
   localparam logic [4:0] OP_SHR  = 5'd9;
   localparam logic [4:0] OP_SHRA = 5'd10;
   localparam logic [4:0] OP_SHL  = 5'd11;
   localparam logic [4:0] OP_ADDI = 5'd12;
   localparam logic [4:0] OP_ANDI = 5'd13;
   localparam logic [4:0] OP_ORI  = 5'd14;
   localparam logic [4:0] OP_DIV  = 5'd15;
   localparam logic [4:0] OP_MUL  = 5'd16;
   localparam logic [4:0] OP_NEG  = 5'd17;
   localparam logic [4:0] OP_NOT  = 5'd18;
   localparam logic [4:0] OP_NOP  = 5'd26;
   localparam logic [4:0] OP_HALT = 5'd27;

   localparam logic [4:0] DRV_HI  = 5'd16;
   localparam logic [4:0] DRV_LO  = 5'd17;
   localparam logic [4:0] DRV_ZHI = 5'd18;
   localparam logic [4:0] DRV_ZLO = 5'd19;
   localparam logic [4:0] DRV_PC  = 5'd20;
   localparam logic [4:0] DRV_MDR = 5'd21;
   localparam logic [4:0] DRV_IN  = 5'd22;
   localparam logic [4:0] DRV_C   = 5'd23;

   typedef enum logic [3:0] {
      ST_IDLE, ST_F0, ST_F1, ST_F2, ST_F3,
      ST_E0, ST_E1, ST_E2, ST_E3, ST_E4,
      ST_HALT
`ifdef SINGLE_STEP_EN
      , ST_PAUSE
`endif
   } state_e;

   typedef enum logic [3:0] {
      CLS_RR, CLS_IMM, CLS_UNARY, CLS_MULDIV,
      CLS_LDI, CLS_LD, CLS_NOP, CLS_HALT, CLS_BAD
   } cls_e;

   typedef struct packed {
      cls_e       cls;
      logic [4:0] opcode;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [3:0] rc;
   } instr_t;

endpackage

// File: rtl/bus_ctrl_sequencer_decode.sv
// -----------------------------------------------------------------------------
// bus_ctrl_decode
// Combinational IR decoder: classifies the opcode and extracts register fields.
// Ports:
//   ir    in  32  instruction register contents
//   instr out     decoded class, opcode, ra/rb/rc
// Any unsupported opcode or an out-of-range register field decodes as CLS_BAD.
// -----------------------------------------------------------------------------
module bus_ctrl_decode
   import bus_ctrl_pkg::*;
#(
   parameter int NUM_GPR = 16
) (
   input  logic [31:0] ir,
   output instr_t      instr
);

   logic [14:0] unused_ir_low;
   assign unused_ir_low = ir[14:0];

   logic ra_ok, rb_ok, rc_ok;
   assign ra_ok = int'(ir[26:23]) < NUM_GPR;
   assign rb_ok = int'(ir[22:19]) < NUM_GPR;
   assign rc_ok = int'(ir[18:15]) < NUM_GPR;

   always_comb begin
      instr.opcode = ir[31:27];
      instr.ra     = ir[26:23];
      instr.rb     = ir[22:19];
      instr.rc     = ir[18:15];
      case (ir[31:27])
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  instr.cls = CLS_RR;
         OP_ADDI, OP_ANDI, OP_ORI:         instr.cls = CLS_IMM;
         OP_NEG, OP_NOT:                   instr.cls = CLS_UNARY;
         OP_MUL, OP_DIV:                   instr.cls = CLS_MULDIV;
         OP_LDI:                           instr.cls = CLS_LDI;
         OP_LD:                            instr.cls = CLS_LD;
         OP_NOP:                           instr.cls = CLS_NOP;
         OP_HALT:                          instr.cls = CLS_HALT;
         default:                          instr.cls = CLS_BAD;
      endcase
      if (!ra_ok || !rb_ok)
         instr.cls = CLS_BAD;
      // rc only matters for reg-reg; an out-of-range rc would select a non-GPR driver
      if (instr.cls == CLS_RR && !rc_ok)
         instr.cls = CLS_BAD;
   end

endmodule

// File: rtl/bus_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// bus_ctrl_sequencer
// Hardwired fetch/execute control-step sequencer for a single-bus datapath.
// Ports:
//   clock, clear (sync active-high), run (sampled in IDLE only)
//   ir[31:0]    instruction register contents
//   mem_ready   memory read data valid
//   step        (SINGLE_STEP_EN only) leaves PAUSE on a one-cycle pulse
//   bus_drv     one-hot bus driver enables (bit = bus select index)
//   r_in        GPR load enables
//   hi_in, lo_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, inc_pc, mem_read
//   alu_op      ALU operation
//   busy, halted, illegal
// Build macro: SINGLE_STEP_EN -- pause after every instruction until step.
// -----------------------------------------------------------------------------
module bus_ctrl_sequencer
   import bus_ctrl_pkg::*;
#(
   parameter int NUM_GPR = 16,
   parameter int DRV_W   = 24
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               run,
   input  logic [31:0]        ir,
   input  logic               mem_ready,
`ifdef SINGLE_STEP_EN
   input  logic               step,
`endif
   output logic [DRV_W-1:0]   bus_drv,
   output logic [NUM_GPR-1:0] r_in,
   output logic               hi_in,
   output logic               lo_in,
   output logic               pc_in,
   output logic               ir_in,
   output logic               mar_in,
   output logic               mdr_in,
   output logic               y_in,
   output logic               z_in,
   output logic               inc_pc,
   output logic               mem_read,
   output logic [4:0]         alu_op,
   output logic               busy,
   output logic               halted,
   output logic               illegal
);

`ifdef SINGLE_STEP_EN
   localparam state_e ST_DONE = ST_PAUSE;
`else
   localparam state_e ST_DONE = ST_F0;
`endif

   state_e state_q, state_d;
   instr_t instr_q, instr_d;
   instr_t dec;
   instr_t cur;

   bus_ctrl_decode #(.NUM_GPR(NUM_GPR)) u_decode (
      .ir    (ir),
      .instr (dec)
   );

   // IR is loaded at the end of F3, so E0 must see the live decode; later steps
   // use the copy captured in E0.
   assign cur = (state_q == ST_E0) ? dec : instr_q;

   function automatic logic [DRV_W-1:0] drv(input logic [4:0] idx);
      return DRV_W'(1) << idx;
   endfunction

   function automatic logic [DRV_W-1:0] drv_gpr(input logic [3:0] r);
      return DRV_W'(1) << {1'b0, r};
   endfunction

   // next-state logic
   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      case (state_q)
         ST_IDLE: if (run) state_d = ST_F0;
         ST_F0:   state_d = ST_F1;
         ST_F1:   state_d = ST_F2;
         ST_F2:   if (mem_ready) state_d = ST_F3;
         ST_F3:   state_d = ST_E0;
         ST_E0: begin
            instr_d = dec;
            case (dec.cls)
               CLS_NOP, CLS_BAD: state_d = ST_DONE;
               CLS_HALT:         state_d = ST_HALT;
               default:          state_d = ST_E1;
            endcase
         end
         ST_E1:   state_d = (cur.cls == CLS_UNARY) ? ST_DONE : ST_E2;
         ST_E2:   state_d = (cur.cls == CLS_MULDIV || cur.cls == CLS_LD) ? ST_E3 : ST_DONE;
         ST_E3: begin
            if (cur.cls == CLS_MULDIV)
               state_d = ST_DONE;
            else if (mem_ready)
               state_d = ST_E4;
         end
         ST_E4:   state_d = ST_DONE;
         ST_HALT: state_d = ST_HALT;
`ifdef SINGLE_STEP_EN
         ST_PAUSE: if (step) state_d = ST_F0;
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= ST_IDLE;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
      end
   end

   // Moore output decode from the registered state and instruction fields
   always_comb begin
      bus_drv  = '0;
      r_in     = '0;
      hi_in    = 1'b0;
      lo_in    = 1'b0;
      pc_in    = 1'b0;
      ir_in    = 1'b0;
      mar_in   = 1'b0;
      mdr_in   = 1'b0;
      y_in     = 1'b0;
      z_in     = 1'b0;
      inc_pc   = 1'b0;
      mem_read = 1'b0;
      alu_op   = 5'd0;
      illegal  = 1'b0;
      halted   = (state_q == ST_HALT);
      busy     = 1'b1;
      case (state_q)
         ST_IDLE, ST_HALT: busy = 1'b0;
`ifdef SINGLE_STEP_EN
         ST_PAUSE: busy = 1'b0;
`endif
         ST_F0: begin
            bus_drv = drv(DRV_PC);
            mar_in  = 1'b1;
            inc_pc  = 1'b1;
            z_in    = 1'b1;
            alu_op  = OP_ADD;
         end
         ST_F1: begin
            bus_drv = drv(DRV_ZLO);
            pc_in   = 1'b1;
         end
         ST_F2: begin
            mem_read = 1'b1;
            mdr_in   = 1'b1;
         end
         ST_F3: begin
            bus_drv = drv(DRV_MDR);
            ir_in   = 1'b1;
         end
         ST_E0: begin
            case (cur.cls)
               CLS_RR, CLS_IMM, CLS_LDI, CLS_LD: begin
                  bus_drv = drv_gpr(cur.rb);
                  y_in    = 1'b1;
               end
               CLS_MULDIV: begin
                  bus_drv = drv_gpr(cur.ra);
                  y_in    = 1'b1;
               end
               CLS_UNARY: begin
                  bus_drv = drv_gpr(cur.rb);
                  z_in    = 1'b1;
                  alu_op  = cur.opcode;
               end
               CLS_BAD: illegal = 1'b1;
               default: ;
            endcase
         end
         ST_E1: begin
            case (cur.cls)
               CLS_RR: begin
                  bus_drv = drv_gpr(cur.rc);
                  z_in    = 1'b1;
                  alu_op  = cur.opcode;
               end
               CLS_IMM: begin
                  bus_drv = drv(DRV_C);
                  z_in    = 1'b1;
                  alu_op  = cur.opcode;
               end
               CLS_LDI, CLS_LD: begin
                  bus_drv = drv(DRV_C);
                  z_in    = 1'b1;
                  alu_op  = OP_ADD;
               end
               CLS_MULDIV: begin
                  bus_drv = drv_gpr(cur.rb);
                  z_in    = 1'b1;
                  alu_op  = cur.opcode;
               end
               CLS_UNARY: begin
                  bus_drv = drv(DRV_ZLO);
                  r_in    = NUM_GPR'(1) << cur.ra;
               end
               default: ;
            endcase
         end
         ST_E2: begin
            bus_drv = drv(DRV_ZLO);
            case (cur.cls)
               CLS_MULDIV: lo_in  = 1'b1;
               CLS_LD:     mar_in = 1'b1;
               default:    r_in   = NUM_GPR'(1) << cur.ra;
            endcase
         end
         ST_E3: begin
            if (cur.cls == CLS_MULDIV) begin
               bus_drv = drv(DRV_ZHI);
               hi_in   = 1'b1;
            end else begin
               mem_read = 1'b1;
               mdr_in   = 1'b1;
            end
         end
         ST_E4: begin
            bus_drv = drv(DRV_MDR);
            r_in    = NUM_GPR'(1) << cur.ra;
         end
         default: busy = 1'b0;
      endcase
   end

endmodule
